pulse_width_capture: RTL and testbench

- Receive-side counterpart of the team's one-shot generators: measures the high time, in clk cycles, of an asynchronous pulse input.
- Delivers each measurement through a single-entry valid/ready output buffer.
- Used to verify trigger/gate widths and to time external sync pulses against the acquisition sample interval.

---
 rtl/pulse_width_capture.sv | 184 ++++++++++++++++++
 tb/tb_pulse_width_capture.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_width_capture.sv
// rtl/pulse_width_capture.sv - measures synchronized high time of pulse_in into a single-entry valid/ready buffer
// Optional PULSE_WIDTH_CAPTURE_PERIOD_EN adds period_out (rise-to-rise count of accepted pulses).
module pulse_width_capture #(
    parameter int COUNTER_WIDTH = 14,
    parameter int MIN_WIDTH     = 2,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     pulse_in,
    input  logic                     enable,
    input  logic                     width_ready,
    output logic [COUNTER_WIDTH-1:0] width_out,
    output logic                     width_valid,
    output logic                     saturated,
    output logic                     overrun,
`ifdef PULSE_WIDTH_CAPTURE_PERIOD_EN
    output logic [COUNTER_WIDTH-1:0] period_out,
`endif
    output logic                     busy
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_WAIT_LOW = 2'd1;
    localparam logic [1:0] ST_MEASURE  = 2'd2;

    localparam logic [COUNTER_WIDTH-1:0] MAX_COUNT = '1;
    localparam logic [COUNTER_WIDTH-1:0] ONE       = COUNTER_WIDTH'(1);
    localparam logic [COUNTER_WIDTH-1:0] MIN_COUNT = COUNTER_WIDTH'(MIN_WIDTH);

    logic [SYNC_STAGES-1:0]   sync_q;
    logic                     s_d_q;
    logic                     s, rise, fall;
    logic [1:0]               state_q, state_d;
    logic [COUNTER_WIDTH-1:0] count_q, count_d;
    logic                     sat_flag_q, sat_flag_d;
    logic                     start, complete, discard, load;
    logic [COUNTER_WIDTH-1:0] width_q, width_d;
    logic                     valid_q, valid_d;
    logic                     sat_q, sat_d;
    logic                     overrun_q, overrun_d;

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_d_q;
    assign fall = ~s & s_d_q;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        sat_flag_d = sat_flag_q;
        start      = 1'b0;
        complete   = 1'b0;
        discard    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable && rise) begin
                    state_d    = ST_MEASURE;
                    count_d    = ONE;
                    sat_flag_d = (ONE == MAX_COUNT);
                    start      = 1'b1;
                end else if (enable && s) begin
                    state_d = ST_WAIT_LOW;
                end
            end
            ST_WAIT_LOW: begin
                if (!s) state_d = ST_IDLE;
            end
            ST_MEASURE: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (fall) begin
                    state_d  = ST_IDLE;
                    complete = (count_q >= MIN_COUNT);
                    discard  = (count_q < MIN_COUNT);
                end else if (s) begin
                    if (count_q != MAX_COUNT) count_d = count_q + ONE;
                    if (count_d == MAX_COUNT) sat_flag_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A completing result loads if the buffer is empty or being drained this same edge.
    assign load = complete & (~valid_q | width_ready);

    always_comb begin
        width_d   = width_q;
        sat_d     = sat_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (load) begin
            width_d = count_q;
            sat_d   = sat_flag_q;
            valid_d = 1'b1;
        end else begin
            if (complete) overrun_d = 1'b1;
            if (valid_q && width_ready) valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q     <= '0;
            s_d_q      <= 1'b0;
            state_q    <= ST_IDLE;
            count_q    <= '0;
            sat_flag_q <= 1'b0;
            width_q    <= '0;
            sat_q      <= 1'b0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], pulse_in};
            s_d_q      <= s;
            state_q    <= state_d;
            count_q    <= count_d;
            sat_flag_q <= sat_flag_d;
            width_q    <= width_d;
            sat_q      <= sat_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
        end
    end

    assign width_out   = width_q;
    assign width_valid = valid_q;
    assign saturated   = sat_q;
    assign overrun     = overrun_q;
    assign busy        = (state_q == ST_MEASURE);

`ifdef PULSE_WIDTH_CAPTURE_PERIOD_EN
    logic [COUNTER_WIDTH-1:0] per_cnt_q, per_cnt_d;
    logic [COUNTER_WIDTH-1:0] carry_q, carry_d;
    logic [COUNTER_WIDTH-1:0] cur_per_q, cur_per_d;
    logic [COUNTER_WIDTH-1:0] period_q, period_d;
    logic                     have_prev_q, have_prev_d;
    logic [COUNTER_WIDTH:0]   per_sum;

    // carry_q bridges glitch rises so the period still spans back to the last accepted pulse.
    assign per_sum = {1'b0, carry_q} + {1'b0, per_cnt_q};

    always_comb begin
        per_cnt_d   = (per_cnt_q == MAX_COUNT) ? MAX_COUNT : per_cnt_q + ONE;
        carry_d     = carry_q;
        cur_per_d   = cur_per_q;
        period_d    = period_q;
        have_prev_d = have_prev_q;
        if (start) begin
            per_cnt_d = ONE;
            cur_per_d = per_sum[COUNTER_WIDTH] ? MAX_COUNT : per_sum[COUNTER_WIDTH-1:0];
        end
        if (load) period_d = have_prev_q ? cur_per_q : '0;
        if (complete) begin
            have_prev_d = 1'b1;
            carry_d     = '0;
        end
        if (discard) carry_d = cur_per_q;
        if (!enable) begin
            have_prev_d = 1'b0;
            carry_d     = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            per_cnt_q   <= '0;
            carry_q     <= '0;
            cur_per_q   <= '0;
            period_q    <= '0;
            have_prev_q <= 1'b0;
        end else begin
            per_cnt_q   <= per_cnt_d;
            carry_q     <= carry_d;
            cur_per_q   <= cur_per_d;
            period_q    <= period_d;
            have_prev_q <= have_prev_d;
        end
    end

    assign period_out = period_q;
`endif

endmodule

// File: tb/tb_pulse_width_capture.sv
// tb/tb_pulse_width_capture.sv - directed table-driven bench for pulse_width_capture
module tb_pulse_width_capture;

    logic        clk;
    logic        reset;
    logic        pulse_in;
    logic        enable;
    logic        width_ready;
    logic [13:0] width_out;
    logic        width_valid;
    logic        saturated;
    logic        overrun;
    logic        busy;
`ifdef PULSE_WIDTH_CAPTURE_PERIOD_EN
    logic [13:0] period_out;
`endif

    pulse_width_capture #(
        .COUNTER_WIDTH(14),
        .MIN_WIDTH    (2),
        .SYNC_STAGES  (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pulse_in   (pulse_in),
        .enable     (enable),
        .width_ready(width_ready),
        .width_out  (width_out),
        .width_valid(width_valid),
        .saturated  (saturated),
        .overrun    (overrun),
`ifdef PULSE_WIDTH_CAPTURE_PERIOD_EN
        .period_out (period_out),
`endif
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int w;
        int s;
        int p;
    } res_t;

    typedef struct {
        int len;
        int n;
        int w;
        int s;
    } vec_t;

    res_t results[$];
    int   n_vec;
    int   n_fail;

    always @(negedge clk) begin
        if (!reset && width_valid && width_ready) begin
            res_t r;
            r.w = int'(width_out);
            r.s = int'(saturated);
`ifdef PULSE_WIDTH_CAPTURE_PERIOD_EN
            r.p = int'(period_out);
`else
            r.p = 0;
`endif
            results.push_back(r);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic pulse(input int len);
        pulse_in = 1'b1;
        tick(len);
        pulse_in = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
    endtask

    vec_t vecs[8];

    initial begin
        n_vec       = 0;
        n_fail      = 0;
        reset       = 1'b1;
        pulse_in    = 1'b0;
        enable      = 1'b0;
        width_ready = 1'b0;

        vecs[0] = '{len: 10,    n: 1, w: 10,    s: 0};
        vecs[1] = '{len: 1,     n: 0, w: 0,     s: 0};
        vecs[2] = '{len: 3,     n: 1, w: 3,     s: 0};
        vecs[3] = '{len: 20000, n: 1, w: 16383, s: 1};
        vecs[4] = '{len: 4,     n: 1, w: 4,     s: 0};
        vecs[5] = '{len: 2,     n: 1, w: 2,     s: 0};
        vecs[6] = '{len: 16382, n: 1, w: 16382, s: 0};
        vecs[7] = '{len: 16383, n: 1, w: 16383, s: 1};

        tick(3);
        reset       = 1'b0;
        enable      = 1'b1;
        width_ready = 1'b1;
        tick(1);
        chk("rst_width_out", int'(width_out), 0);
        chk("rst_width_valid", int'(width_valid), 0);
        chk("rst_saturated", int'(saturated), 0);
        chk("rst_overrun", int'(overrun), 0);
        chk("rst_busy", int'(busy), 0);

        for (int i = 0; i < 8; i++) begin
            results.delete();
            pulse(vecs[i].len);
            tick(12);
            chk($sformatf("vec%0d_count", i), results.size(), vecs[i].n);
            if (vecs[i].n == 1 && results.size() == 1) begin
                chk($sformatf("vec%0d_width", i), results[0].w, vecs[i].w);
                chk($sformatf("vec%0d_sat", i), results[0].s, vecs[i].s);
            end
            chk($sformatf("vec%0d_overrun", i), int'(overrun), 0);
        end

        // Buffer full: second result dropped, overrun sticky.
        do_reset();
        width_ready = 1'b0;
        pulse(5);
        tick(4);
        pulse(7);
        tick(12);
        chk("ovr_valid", int'(width_valid), 1);
        chk("ovr_width_held", int'(width_out), 5);
        chk("ovr_flag", int'(overrun), 1);
        width_ready = 1'b1;
        tick(1);
        width_ready = 1'b0;
        chk("ovr_valid_cleared", int'(width_valid), 0);
        chk("ovr_width_after", int'(width_out), 5);
        chk("ovr_flag_sticky", int'(overrun), 1);

        // enable rising while pulse already high must not measure it.
        do_reset();
        width_ready = 1'b1;
        enable      = 1'b0;
        results.delete();
        pulse_in = 1'b1;
        tick(5);
        enable = 1'b1;
        begin
            int busy_seen;
            busy_seen = 0;
            for (int k = 0; k < 10; k++) begin
                tick(1);
                if (busy) busy_seen = 1;
            end
            pulse_in = 1'b0;
            tick(12);
            chk("late_en_busy", busy_seen, 0);
        end
        chk("late_en_count", results.size(), 0);
        pulse(8);
        tick(12);
        chk("after_late_count", results.size(), 1);
        if (results.size() == 1) chk("after_late_width", results[0].w, 8);

        // enable dropped mid-pulse aborts.
        results.delete();
        pulse_in = 1'b1;
        tick(6);
        enable = 1'b0;
        tick(4);
        pulse_in = 1'b0;
        tick(2);
        enable = 1'b1;
        tick(12);
        chk("abort_count", results.size(), 0);
        chk("abort_overrun", int'(overrun), 0);

        // Reset mid-measure clears everything, including the held width_out of 8.
        results.delete();
        pulse_in = 1'b1;
        tick(20);
        chk("mid_busy", int'(busy), 1);
        reset = 1'b1;
        tick(1);
        chk("midrst_width_out", int'(width_out), 0);
        chk("midrst_valid", int'(width_valid), 0);
        chk("midrst_busy", int'(busy), 0);
        tick(29);
        pulse_in = 1'b0;
        tick(4);
        reset = 1'b0;
        tick(12);
        chk("midrst_count", results.size(), 0);

        // Back-to-back with a single low cycle between pulses.
        results.delete();
        pulse(3);
        tick(1);
        pulse(4);
        tick(12);
        chk("b2b_count", results.size(), 2);
        if (results.size() == 2) begin
            chk("b2b_first", results[0].w, 3);
            chk("b2b_second", results[1].w, 4);
        end

`ifdef PULSE_WIDTH_CAPTURE_PERIOD_EN
        do_reset();
        results.delete();
        pulse(10);
        tick(90);
        pulse(10);
        tick(12);
        chk("per_count", results.size(), 2);
        if (results.size() == 2) begin
            chk("per_first", results[0].p, 0);
            chk("per_second", results[1].p, 100);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
